mac_vec: RTL
============

Name: mac_vec

Overview:
- Parametrised, pipelined signed multiply-accumulate engine; successor to the single-channel 8x8 MAC.
- Accumulates a vector of LEN valid (a,b) pairs into a dot product, then emits a one-cycle result strobe and auto-restarts for the next vector.
- Adds valid qualification, a two-stage pipeline, optional saturation and a per-vector overflow flag.
- Sits between the sample/weight fetch logic and downstream result consumers.

Parameters:
- DATA_W, 8: signed width of a and b.
- ACC_W, 26: signed accumulator/result width. Must be >= 2*DATA_W; checked at elaboration.
- LEN, 16: pairs per vector. Must be >= 1.
- SAT, 1: 1 = saturate at signed ACC_W limits; 0 = two's-complement wrap.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr_n  in  1  synchronous active-low clear: flush pipeline, zero accumulator and counter.
- in_valid  in  1  a/b valid this cycle; no backpressure, every valid pair is consumed.
- a  in  DATA_W  signed operand.
- b  in  DATA_W  signed operand.
- acc  out  ACC_W  running partial sum, registered.
- cnt  out  $clog2(LEN+1)  pairs accumulated in the current vector.
- out_valid  out  1  one-cycle strobe: result/out_ovf hold a completed vector.
- result  out  ACC_W  completed dot product; holds until the next strobe.
- out_ovf  out  1  vector saturated/wrapped at least once; qualified by out_valid, holds with result.

Behaviour:
- Reset (rst=1, asynchronous) clears acc, cnt, result, out_valid, out_ovf, stage-1 valid and product, and the internal sticky overflow to 0.
- Stage 1 (edge after accept): p1 <= a*b, full 2*DATA_W signed; v1 <= in_valid.
- Stage 2 (next edge, when v1=1):
  - sum = acc + sign_extend(p1) computed at ACC_W+1 bits.
  - Overflow when the two top bits of sum differ.
  - SAT=1: clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1). SAT=0: keep the low ACC_W bits.
- Latency: a pair accepted at edge N is reflected in acc after edge N+2.
- Vector completion happens when v1=1 and cnt==LEN-1. On that edge:
  - result <= sum (clamped or wrapped).
  - out_ovf <= sticky | this-cycle overflow.
  - out_valid <= 1.
  - acc <= 0, cnt <= 0, sticky <= 0.
- Otherwise, when v1=1: acc <= sum, cnt <= cnt+1, sticky |= overflow.
- out_valid is 1 for exactly one cycle per completed vector. It is 0 on all other cycles, including when v1=0.
- Bubbles (in_valid=0) are allowed anywhere and do not change acc or cnt.
- Back-to-back vectors need no gap. Pair 0 of the next vector may be accepted one edge after the last pair of the previous vector.
- clr_n=0 at an edge:
  - acc, cnt, sticky, v1 <= 0.
  - A pair presented in the same cycle is discarded; clear wins.
  - Any in-flight stage-1 pair is discarded.
  - result and out_ovf keep their values; out_valid <= 0.
- clr_n=0 on the completion edge: no strobe is produced and the vector is lost.
- LEN=1: every valid pair produces a strobe two edges later; acc stays 0.
- Width rule: a product is never truncated; it is sign-extended to ACC_W. Worst case (-2^(DATA_W-1))^2 is positive and fits because ACC_W >= 2*DATA_W.

Decomposition:
- Package mac_pkg holds:
  - the saturate/overflow function `sat_add(acc, p, sat_en)` returning {ovf, value};
  - localparam defaults DATA_W_DEF=8, ACC_W_DEF=26, LEN_DEF=16.
- One sub-module, mac_vec_sat_add: combinational ACC_W+1 adder with clamp. It is reused by future multi-lane MACs.
- Counter and pipeline registers stay in mac_vec.

Test Plan:
- Defaults. Reset mid-vector after 5 pairs, then 16 pairs a=3, b=-2 -> out_valid single pulse 2 cycles after pair 16; result=-96, out_ovf=0.
- Mixed signs with bubbles. Defaults; pairs (-128,-128) x8 and (127,-128) x8, one idle cycle between each -> result=8*16384-8*16256=1024; cnt and acc unchanged during bubbles.
- Saturation. ACC_W=16, SAT=1, LEN=4; pairs (-128,-128) x4 -> acc saturates at 32767 from pair 2; result=32767, out_ovf=1. Next vector of (1,1) x4 -> result=4, out_ovf=0.
- Wrap. ACC_W=16, SAT=0, LEN=2; (-128,-128) x2 -> result=-32768, out_ovf=1.
- Clear collision. clr_n=0 on the cycle of pair 10 of 16 -> no strobe, acc=0 and cnt=0 next cycle; the following 16 pairs a=1, b=1 -> result=16.
- Back-to-back and async reset. Continuous in_valid for 48 pairs (LEN=16, a=b=2) -> strobes at pairs 16, 32, 48, each result=64, exactly 16 cycles apart. Assert rst between clock edges -> all outputs 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types, defaults and the saturating/wrapping add used by mac_vec and
// future multi-lane MACs.
package mac_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 26;
    localparam int LEN_DEF    = 16;

    // Widest accumulator the shared add supports; callers sign-extend into it.
    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    // Adds two values already sign-extended from acc_w bits and returns
    // {ovf, value}. The value is clamped when sat_en is set, otherwise it is
    // the raw sum whose low acc_w bits are the wrapped result.
    function automatic logic [MAX_W:0] sat_add(input wide_t acc, input wide_t p,
                                                input logic sat_en, input int acc_w);
        wide_t sum;
        wide_t hi;
        wide_t lo;
        wide_t val;
        logic  ovf;
        sum = acc + p;
        hi  = (wide_t'(1) <<< (acc_w - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (acc_w - 1));
        ovf = (sum > hi) || (sum < lo);
        if (!ovf || !sat_en)
            val = sum;
        else if (sum > hi)
            val = hi;
        else
            val = lo;
        return {ovf, val};
    endfunction

endpackage

// File: rtl/mac_vec_sat_add.sv
// Combinational accumulator add with overflow detect and optional clamp to
// the signed ACC_W range.
module mac_vec_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int P_W   = 2 * DATA_W_DEF,
    parameter bit SAT   = 1'b1
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [P_W-1:0]   p,
    output logic signed [ACC_W-1:0] sum,
    output logic                    ovf
);

    if (ACC_W >= MAX_W) begin : g_bad_acc_w
        $error("mac_vec_sat_add: ACC_W must be below %0d", MAX_W);
    end

    logic [MAX_W:0] res;
    logic           unused_hi;

    assign res       = sat_add(wide_t'(acc), wide_t'(p), SAT, ACC_W);
    assign sum       = res[ACC_W-1:0];
    assign ovf       = res[MAX_W];
    // Upper bits only carry sign/clamp information already reflected in sum.
    assign unused_hi = ^res[MAX_W-1:ACC_W];

endmodule

// File: rtl/mac_vec.sv
// Two-stage pipelined signed vector MAC: multiplies valid (a,b) pairs and
// emits a one-cycle result strobe every LEN pairs, then restarts.
module mac_vec
    import mac_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN    = LEN_DEF,
    parameter bit SAT    = 1'b1,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_n,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]         cnt,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  result,
    output logic                     out_ovf
);

    localparam int P_W = 2 * DATA_W;

    if (ACC_W < P_W) begin : g_bad_acc_w
        $error("mac_vec: ACC_W (%0d) must be >= 2*DATA_W (%0d)", ACC_W, P_W);
    end
    if (LEN < 1) begin : g_bad_len
        $error("mac_vec: LEN must be >= 1");
    end

    logic signed [P_W-1:0]   p1;
    logic                    v1;
    logic                    sticky;
    logic signed [ACC_W-1:0] sum;
    logic                    ovf;
    logic                    last;

    assign last = (cnt == CNT_W'(LEN - 1));

    mac_vec_sat_add #(
        .ACC_W (ACC_W),
        .P_W   (P_W),
        .SAT   (SAT)
    ) u_sat_add (
        .acc (acc),
        .p   (p1),
        .sum (sum),
        .ovf (ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1        <= '0;
            v1        <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            out_ovf   <= 1'b0;
        end else if (!clr_n) begin
            // Clear drops both the incoming pair and the one in stage 1;
            // the last completed result stays visible.
            p1        <= '0;
            v1        <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            p1        <= P_W'(a) * P_W'(b);
            v1        <= in_valid;
            out_valid <= 1'b0;
            if (v1) begin
                if (last) begin
                    result    <= sum;
                    out_ovf   <= sticky | ovf;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                    sticky    <= 1'b0;
                end else begin
                    acc    <= sum;
                    cnt    <= cnt + CNT_W'(1);
                    sticky <= sticky | ovf;
                end
            end
        end
    end

endmodule
